// File: rtl/ysyx_23060042_idu_stage.sv
// RV32I instruction-decode stage: decodes IFU instructions into micro-ops and
// buffers them in a small FIFO with an optional same-cycle bypass to the EXU.
module ysyx_23060042_idu_stage #(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1,
    parameter int PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_func3,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_imm,
    output logic [2:0]               out_imm_type,
    output logic                     out_regen,
    output logic                     out_illegal,
    output logic                     out_ebreak,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b110;
    localparam logic [2:0] IMM_J = 3'b111;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [2:0]      imm_type;
        logic            regen;
        logic            illegal;
        logic            ebreak;
    } uop_t;

    function automatic uop_t decode(input logic [31:0] inst, input logic [PC_W-1:0] pc);
        uop_t u;
        logic known;
        u.pc       = pc;
        u.opcode   = inst[6:0];
        u.func3    = inst[14:12];
        u.rs1      = inst[19:15];
        u.rs2      = inst[24:20];
        u.rd       = inst[11:7];
        u.imm      = 32'h0000_0000;
        u.imm_type = IMM_R;
        u.regen    = 1'b0;
        known      = 1'b1;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                u.imm      = {inst[31:12], 12'h000};
                u.imm_type = IMM_U;
                u.regen    = 1'b1;
            end
            OP_JAL: begin
                u.imm      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                u.imm_type = IMM_J;
                u.regen    = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                u.imm      = {{20{inst[31]}}, inst[31:20]};
                u.imm_type = IMM_I;
                u.regen    = 1'b1;
            end
            OP_STORE: begin
                u.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                u.imm_type = IMM_S;
            end
            OP_BRANCH: begin
                u.imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                u.imm_type = IMM_B;
            end
            OP_OP: begin
                u.regen = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                u.regen = 1'b0;
            end
            default: begin
                known = 1'b0;
            end
        endcase
        u.ebreak  = (inst == INST_EBREAK);
        u.illegal = (inst[1:0] != 2'b11) || !known ||
                    ((inst[6:0] == OP_SYSTEM) && (inst != INST_EBREAK) && (inst != INST_ECALL));
        // Writes to x0 and illegal encodings never update the register file.
        u.regen   = u.regen && (inst[11:7] != 5'd0) && !u.illegal;
        return u;
    endfunction

    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    uop_t             mem_r [DEPTH];
    uop_t             dec_s;
    uop_t             sel_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_s;
    logic             out_valid_s;
    logic             in_ready_s;

    assign dec_s = decode(in_inst, in_pc);

    // Handshake control: readiness, output validity, push/pop qualification.
    always_comb begin
        in_ready_s  = !rst && !flush && (count_r != FULL_CNT);
        bypass_s    = 1'b0;
        out_valid_s = 1'b0;
        if (count_r != ZERO_CNT) begin
            out_valid_s = !rst && !flush;
        end else if (BYPASS) begin
            bypass_s    = 1'b1;
            out_valid_s = in_valid && !flush && !rst;
        end else begin
            out_valid_s = 1'b0;
        end
        pop_s  = out_valid_s && out_ready && (count_r != ZERO_CNT);
        // A bypassed instruction consumed downstream in the same cycle is never stored.
        push_s = in_valid && in_ready_s && !(bypass_s && out_ready);
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= ZERO_CNT;
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else if (flush) begin
            count_r  <= ZERO_CNT;
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Micro-op storage; contents are only observed through a valid count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dec_s;
        end
    end

    // Output selection: live decode while bypassing, else FIFO head; zero when idle.
    always_comb begin
        sel_s = '0;
        if (!out_valid_s) begin
            sel_s = '0;
        end else if (bypass_s) begin
            sel_s = dec_s;
        end else begin
            sel_s = mem_r[rd_ptr_r];
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_s;
    assign out_pc       = sel_s.pc;
    assign out_opcode   = sel_s.opcode;
    assign out_func3    = sel_s.func3;
    assign out_rs1      = sel_s.rs1;
    assign out_rs2      = sel_s.rs2;
    assign out_rd       = sel_s.rd;
    assign out_imm      = sel_s.imm;
    assign out_imm_type = sel_s.imm_type;
    assign out_regen    = sel_s.regen;
    assign out_illegal  = sel_s.illegal;
    assign out_ebreak   = sel_s.ebreak;
    assign occupancy    = count_r;

endmodule

// File: tb/tb_ysyx_23060042_idu_stage.sv
// Bench for the decode stage: a bypassing and a registered instance share stimulus.
module tb_ysyx_23060042_idu_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic [31:0] in_pc = 32'h0;

    logic        b_in_ready, b_out_valid, b_out_regen, b_out_illegal, b_out_ebreak;
    logic [31:0] b_out_pc, b_out_imm;
    logic [6:0]  b_out_opcode;
    logic [2:0]  b_out_func3, b_out_imm_type, b_occupancy;
    logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;

    logic        r_in_ready, r_out_valid, r_out_regen, r_out_illegal, r_out_ebreak;
    logic [31:0] r_out_pc, r_out_imm;
    logic [6:0]  r_out_opcode;
    logic [2:0]  r_out_func3, r_out_imm_type, r_occupancy;
    logic [4:0]  r_out_rs1, r_out_rs2, r_out_rd;

    always #5 clk = ~clk;

    ysyx_23060042_idu_stage #(.DEPTH(DEPTH), .BYPASS(1'b1), .PC_W(32)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_opcode(b_out_opcode), .out_func3(b_out_func3),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_imm(b_out_imm),
        .out_imm_type(b_out_imm_type), .out_regen(b_out_regen), .out_illegal(b_out_illegal),
        .out_ebreak(b_out_ebreak), .occupancy(b_occupancy)
    );

    ysyx_23060042_idu_stage #(.DEPTH(DEPTH), .BYPASS(1'b0), .PC_W(32)) dut_r (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(r_out_valid), .out_ready(out_ready),
        .out_pc(r_out_pc), .out_opcode(r_out_opcode), .out_func3(r_out_func3),
        .out_rs1(r_out_rs1), .out_rs2(r_out_rs2), .out_rd(r_out_rd), .out_imm(r_out_imm),
        .out_imm_type(r_out_imm_type), .out_regen(r_out_regen), .out_illegal(r_out_illegal),
        .out_ebreak(r_out_ebreak), .occupancy(r_occupancy)
    );

    logic [94:0] b_dec, r_dec;
    logic [56:0] b_data, r_data;
    assign b_dec = {b_out_pc, b_out_opcode, b_out_func3, b_out_rs1, b_out_rs2, b_out_rd,
                    b_out_imm, b_out_imm_type, b_out_regen, b_out_illegal, b_out_ebreak};
    assign r_dec = {r_out_pc, r_out_opcode, r_out_func3, r_out_rs1, r_out_rs2, r_out_rd,
                    r_out_imm, r_out_imm_type, r_out_regen, r_out_illegal, r_out_ebreak};
    assign b_data = {b_out_pc, b_out_opcode, b_out_func3, b_out_rd, b_out_rs1, b_out_rs2};
    assign r_data = {r_out_pc, r_out_opcode, r_out_func3, r_out_rd, r_out_rs1, r_out_rs2};

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  it;
        logic        regen;
        logic        ill;
        logic        eb;
    } tv_t;

    tv_t tv [16];
    int  n_cmp = 0;
    int  n_fail = 0;

    function automatic tv_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic [6:0] op,
                               input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm, input logic [2:0] it,
                               input logic regen, input logic ill, input logic eb);
        tv_t t;
        t.inst = inst; t.pc = pc; t.op = op; t.f3 = f3; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.imm = imm; t.it = it; t.regen = regen; t.ill = ill; t.eb = eb;
        return t;
    endfunction

    function automatic logic [94:0] tv_exp(input tv_t t);
        return {t.pc, t.op, t.f3, t.rs1, t.rs2, t.rd, t.imm, t.it, t.regen, t.ill, t.eb};
    endfunction

    function automatic logic [56:0] data_of(input logic [63:0] e);
        return {e[63:32], e[6:0], e[14:12], e[11:7], e[19:15], e[24:20]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [63:0] qb[$];
    logic [63:0] qr[$];
    logic        e_rdy, e_vld, acc, con;
    logic [63:0] e_item;
    logic [61:0] e_obs;
    int          seq;

    initial begin
        tv[0]  = mk(32'h00500093, 32'h80000000, 7'h13, 3'd0, 5'd0,  5'd5,  5'd1,  32'h00000005, 3'b001, 1'b1, 1'b0, 1'b0);
        tv[1]  = mk(32'h12345137, 32'h80000004, 7'h37, 3'd5, 5'd8,  5'd3,  5'd2,  32'h12345000, 3'b110, 1'b1, 1'b0, 1'b0);
        tv[2]  = mk(32'hFE000EE3, 32'h80000008, 7'h63, 3'd0, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 3'b011, 1'b0, 1'b0, 1'b0);
        tv[3]  = mk(32'h00512423, 32'h8000000C, 7'h23, 3'd2, 5'd2,  5'd5,  5'd8,  32'h00000008, 3'b010, 1'b0, 1'b0, 1'b0);
        tv[4]  = mk(32'h00100073, 32'h80000010, 7'h73, 3'd0, 5'd0,  5'd1,  5'd0,  32'h00000000, 3'b000, 1'b0, 1'b0, 1'b1);
        tv[5]  = mk(32'h00000073, 32'h80000014, 7'h73, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0);
        tv[6]  = mk(32'hFFFFFFFF, 32'h80000018, 7'h7F, 3'd7, 5'd31, 5'd31, 5'd31, 32'h00000000, 3'b000, 1'b0, 1'b1, 1'b0);
        tv[7]  = mk(32'h010000EF, 32'h8000001C, 7'h6F, 3'd0, 5'd0,  5'd16, 5'd1,  32'h00000010, 3'b111, 1'b1, 1'b0, 1'b0);
        tv[8]  = mk(32'h00008067, 32'h80000020, 7'h67, 3'd0, 5'd1,  5'd0,  5'd0,  32'h00000000, 3'b001, 1'b0, 1'b0, 1'b0);
        tv[9]  = mk(32'hFFC12503, 32'h80000024, 7'h03, 3'd2, 5'd2,  5'd28, 5'd10, 32'hFFFFFFFC, 3'b001, 1'b1, 1'b0, 1'b0);
        tv[10] = mk(32'h002081B3, 32'h80000028, 7'h33, 3'd0, 5'd1,  5'd2,  5'd3,  32'h00000000, 3'b000, 1'b1, 1'b0, 1'b0);
        tv[11] = mk(32'hFFFFF297, 32'h8000002C, 7'h17, 3'd7, 5'd31, 5'd31, 5'd5,  32'hFFFFF000, 3'b110, 1'b1, 1'b0, 1'b0);
        tv[12] = mk(32'h30001073, 32'h80000030, 7'h73, 3'd1, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'b000, 1'b0, 1'b1, 1'b0);
        tv[13] = mk(32'h00000010, 32'h80000034, 7'h10, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'b000, 1'b0, 1'b1, 1'b0);
        tv[14] = mk(32'h0FF0000F, 32'h80000038, 7'h0F, 3'd0, 5'd0,  5'd31, 5'd0,  32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0);
        tv[15] = mk(32'h00000013, 32'h8000003C, 7'h13, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'b001, 1'b0, 1'b0, 1'b0);

        // Reset state, with an instruction offered to probe the bypass gating.
        in_valid = 1'b1; in_inst = 32'h00500093; out_ready = 1'b1;
        #1;
        check("rst_b", 128'({b_in_ready, b_out_valid, b_occupancy}), 128'(5'b00000));
        check("rst_r", 128'({r_in_ready, r_out_valid, r_occupancy}), 128'(5'b00000));
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rel_rdy", 128'({b_in_ready, r_in_ready, b_out_valid, r_out_valid}), 128'(4'b1100));

        // Decode table: bypass shows it live, registered instance one cycle later.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; in_inst = tv[i].inst; in_pc = tv[i].pc;
            #1;
            check($sformatf("dec_b[%0d]", i), 128'({b_out_valid, b_occupancy, b_dec}), 128'({1'b1, 3'd0, tv_exp(tv[i])}));
            if (i == 0) check("dec_r[0]", 128'({r_out_valid, r_occupancy}), 128'({1'b0, 3'd0}));
            else check($sformatf("dec_r[%0d]", i), 128'({r_out_valid, r_occupancy, r_dec}), 128'({1'b1, 3'd1, tv_exp(tv[i-1])}));
        end
        do_reset();

        // Registered path: one-cycle latency and hold while stalled.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; in_inst = tv[1].inst; in_pc = tv[1].pc;
        #1;
        check("r_lat0", 128'(r_out_valid), 128'(1'b0));
        @(negedge clk);
        in_inst = tv[2].inst; in_pc = tv[2].pc;
        #1;
        check("r_lui", 128'({r_out_valid, r_occupancy, r_dec}), 128'({1'b1, 3'd1, tv_exp(tv[1])}));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("r_hold", 128'({r_out_valid, r_occupancy, r_dec}), 128'({1'b1, 3'd2, tv_exp(tv[1])}));
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("r_pop1", 128'({r_out_valid, r_dec}), 128'({1'b1, tv_exp(tv[1])}));
        @(negedge clk);
        #1;
        check("r_beq", 128'({r_out_valid, r_occupancy, r_dec}), 128'({1'b1, 3'd1, tv_exp(tv[2])}));
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("r_empty", 128'({r_out_valid, r_occupancy}), 128'({1'b0, 3'd0}));
        do_reset();

        // Fill to DEPTH, then drain with in_valid held: ordered, one pop per cycle.
        out_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = 32'h00000013 | (32'(k) << 7); in_pc = 32'h1000 + 32'(k) * 32'd4;
        end
        @(negedge clk);
        in_inst = 32'h00000013 | (32'd5 << 7); in_pc = 32'h1000 + 32'd20;
        #1;
        check("full_b", 128'({b_in_ready, b_out_valid, b_occupancy, b_out_pc}), 128'({1'b0, 1'b1, 3'd4, 32'h1004}));
        check("full_r", 128'({r_in_ready, r_out_valid, r_occupancy, r_out_pc}), 128'({1'b0, 1'b1, 3'd4, 32'h1004}));
        out_ready = 1'b1;
        #1;
        check("full_nopass", 128'({b_in_ready, b_out_pc}), 128'({1'b0, 32'h1004}));
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            in_inst = 32'h00000013 | (32'(k + 3) << 7); in_pc = 32'h1000 + 32'(k + 3) * 32'd4;
            #1;
            check($sformatf("drain_b[%0d]", k), 128'({b_in_ready, b_occupancy, b_out_pc, b_out_rd}),
                  128'({1'b1, 3'd3, 32'h1000 + 32'(k) * 32'd4, 5'(k)}));
            check($sformatf("drain_r[%0d]", k), 128'({r_in_ready, r_occupancy, r_out_pc}),
                  128'({1'b1, 3'd3, 32'h1000 + 32'(k) * 32'd4}));
        end
        do_reset();

        // Flush with three entries buffered and an instruction on offer.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = tv[k].inst; in_pc = tv[k].pc;
        end
        @(negedge clk);
        flush = 1'b1; in_inst = tv[3].inst; in_pc = tv[3].pc;
        #1;
        check("flush_b", 128'({b_out_valid, b_in_ready, b_occupancy}), 128'({1'b0, 1'b0, 3'd3}));
        check("flush_r", 128'({r_out_valid, r_in_ready, r_occupancy}), 128'({1'b0, 1'b0, 3'd3}));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("post_flush", 128'({b_out_valid, b_occupancy, r_out_valid, r_occupancy}), 128'(8'h00));
        do_reset();

        // Random traffic against an ordered queue model for each instance.
        qb.delete(); qr.delete(); seq = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 63) == 0);
            in_inst   = $urandom;
            in_pc     = 32'h80000000 + 32'(seq) * 32'd4;
            seq++;
            #1;
            e_rdy = !flush && (qb.size() != DEPTH);
            e_vld = !flush && ((qb.size() != 0) || in_valid);
            if (qb.size() != 0) e_item = qb[0];
            else e_item = {in_pc, in_inst};
            e_obs = {e_rdy, e_vld, 3'(qb.size()), e_vld ? data_of(e_item) : 57'd0};
            check("rand_b", 128'({b_in_ready, b_out_valid, b_occupancy, b_data}), 128'(e_obs));
            acc = in_valid && e_rdy;
            con = e_vld && out_ready;
            if (flush) qb.delete();
            else if (!((qb.size() == 0) && acc && con)) begin
                if (con) void'(qb.pop_front());
                if (acc) qb.push_back({in_pc, in_inst});
            end
            e_rdy = !flush && (qr.size() != DEPTH);
            e_vld = !flush && (qr.size() != 0);
            e_item = 64'd0;
            if (qr.size() != 0) e_item = qr[0];
            e_obs = {e_rdy, e_vld, 3'(qr.size()), e_vld ? data_of(e_item) : 57'd0};
            check("rand_r", 128'({r_in_ready, r_out_valid, r_occupancy, r_data}), 128'(e_obs));
            acc = in_valid && e_rdy;
            con = e_vld && out_ready;
            if (flush) qr.delete();
            else begin
                if (con) void'(qr.pop_front());
                if (acc) qr.push_back({in_pc, in_inst});
            end
        end

        // Asynchronous reset mid-stream with entries buffered.
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_b", 128'({b_out_valid, b_in_ready, b_occupancy}), 128'(5'b00000));
        check("arst_r", 128'({r_out_valid, r_in_ready, r_occupancy}), 128'(5'b00000));
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
